spi_frame_builder: RTL and testbench

SPI_FRAME_BUILDER -- requirements
Module: spi_frame_builder

---
 rtl/spi_frame_builder.sv | 142 ++++++++++++++
 tb/tb_spi_frame_builder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_builder.sv
// Builds a fixed SPI tx frame {time, cnt0..cnt(NCNT-1), crc} from periodic snapshots and
// publishes it only while no SPI transfer is active. Define FRAME_CRC_EN to add a CRC-32/BZIP2 word.
module spi_frame_builder #(
    parameter int NCNT = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ssel,
    input  logic [31:0]              time_in,
    input  logic [32*NCNT-1:0]       cnt_flat,
    output logic [32*(NCNT+2)-1:0]   frame_out,
    output logic                     frame_valid,
    output logic [7:0]               frame_seq
);
    localparam int SNAP_W = 32*(NCNT+1);
    localparam int FW     = 32*(NCNT+2);

    typedef enum logic [1:0] {IDLE, CRC, PUBLISH} state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [SNAP_W-1:0]   snap_q, snap_d, snap_in;
    logic [FW-1:0]       frame_q, frame_d;
    logic                valid_q, valid_d;
    logic [7:0]          seq_q, seq_d;
    logic [31:0]         crc_word;
    logic                transfer_active;

    // Snapshot word order: time in the top word, then cnt0 downward to cnt(NCNT-1).
    assign snap_in[SNAP_W-1 -: 32] = time_in;
    for (genvar gi = 0; gi < NCNT; gi++) begin : g_snap
        assign snap_in[32*(NCNT-1-gi) +: 32] = cnt_flat[32*gi +: 32];
    end

    assign transfer_active = ~sync2_q;

`ifdef FRAME_CRC_EN
    localparam int NBYTES = 4*(NCNT+1);
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int SEL_W  = $clog2(SNAP_W);

    logic [31:0]      crc_q, crc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] byte_lsb;
    logic [7:0]       cur_byte;

    // Non-reflected CRC-32 update, MSB of the data byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {data, 24'h0};
        for (int b = 0; b < 8; b++) begin
            c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        end
        return c;
    endfunction

    assign byte_lsb = SEL_W'(8*(NBYTES-1-int'(idx_q)));
    assign cur_byte = snap_q[byte_lsb +: 8];
    assign crc_word = ~crc_q;
`else
    assign crc_word = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            snap_q  <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            seq_q   <= 8'd0;
`ifdef FRAME_CRC_EN
            crc_q   <= 32'hFFFFFFFF;
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= ssel;
            sync2_q <= sync1_q;
            snap_q  <= snap_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            seq_q   <= seq_d;
`ifdef FRAME_CRC_EN
            crc_q   <= crc_d;
            idx_q   <= idx_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        frame_d = frame_q;
        valid_d = valid_q;
        seq_d   = seq_q;
`ifdef FRAME_CRC_EN
        crc_d   = crc_q;
        idx_d   = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (!transfer_active) begin
                    snap_d = snap_in;
`ifdef FRAME_CRC_EN
                    crc_d   = 32'hFFFFFFFF;
                    idx_d   = '0;
                    state_d = CRC;
`else
                    state_d = PUBLISH;
`endif
                end
            end
            CRC: begin
`ifdef FRAME_CRC_EN
                // A transfer starting here does not abort; only PUBLISH looks at it.
                crc_d = crc32_byte(crc_q, cur_byte);
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NBYTES-1)) begin
                    state_d = PUBLISH;
                end
`else
                state_d = IDLE;
`endif
            end
            PUBLISH: begin
                if (!transfer_active) begin
                    frame_d = {snap_q, crc_word};
                    valid_d = 1'b1;
                    seq_d   = seq_q + 8'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign frame_out   = frame_q;
    assign frame_valid = valid_q;
    assign frame_seq   = seq_q;
endmodule

// File: tb/tb_spi_frame_builder.sv
// Randomized bench for spi_frame_builder: an event-level frame model is compared every cycle,
// plus literal checks of the CRC check value, latency, reset, wrap and transfer hold behaviour.
module tb_spi_frame_builder;
    localparam int NCNT = 10;
    localparam int FW   = 32*(NCNT+2);
`ifdef FRAME_CRC_EN
    localparam int LAT = 45;
`else
    localparam int LAT = 1;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  ssel = 1'b1;
    logic [31:0]           time_in = 32'h0;
    logic [32*NCNT-1:0]    cnt_flat = '0;
    logic [FW-1:0]         frame_out;
    logic                  frame_valid;
    logic [7:0]            frame_seq;

    int n_checks = 0;
    int n_pass   = 0;

    spi_frame_builder #(.NCNT(NCNT)) dut (
        .clk(clk), .rst(rst), .ssel(ssel), .time_in(time_in), .cnt_flat(cnt_flat),
        .frame_out(frame_out), .frame_valid(frame_valid), .frame_seq(frame_seq)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Bit-serial CRC-32/BZIP2 over n bytes.
    function automatic logic [31:0] crc_ref(input logic [7:0] data [0:63], input int n);
        logic [31:0] r;
        logic [7:0]  d;
        logic        fb;
        r = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            d = data[i];
            for (int k = 0; k < 8; k++) begin
                fb = r[31] ^ d[7];
                d  = d << 1;
                r  = r << 1;
                if (fb) r = r ^ 32'h04C11DB7;
            end
        end
        return ~r;
    endfunction

    function automatic logic [FW-1:0] make_frame(input logic [31:0] t, input logic [32*NCNT-1:0] c);
        logic [FW-1:0]      f;
        logic [31:0]        w;
        logic [31:0]        crc;
        logic [32*NCNT-1:0] sh;
        logic [7:0]         b [0:63];
        for (int i = 0; i < 64; i++) b[i] = 8'h0;
        f = FW'(t);
        for (int k = 0; k < 4; k++) b[k] = 8'(t >> (24-8*k));
        for (int i = 0; i < NCNT; i++) begin
            sh = c >> (32*i);
            w  = sh[31:0];
            f  = (f << 32) | FW'(w);
            for (int k = 0; k < 4; k++) b[4+4*i+k] = 8'(w >> (24-8*k));
        end
`ifdef FRAME_CRC_EN
        crc = crc_ref(b, 4*(NCNT+1));
`else
        crc = 32'h0;
`endif
        return (f << 32) | FW'(crc);
    endfunction

    // Model: a snapshot is taken on any idle edge seeing no transfer; the frame is due LAT
    // edges later and is published only if no transfer is seen at that edge.
    logic               m_s1 = 1'b1, m_s2 = 1'b1, m_busy = 1'b0;
    int                 cyc = 0, m_due = 0;
    logic [31:0]        m_t = 32'h0;
    logic [32*NCNT-1:0] m_c = '0;
    logic [FW-1:0]      m_frame = '0;
    logic               m_valid = 1'b0;
    logic [7:0]         m_seq = 8'd0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_busy = 1'b0;
            m_frame = '0; m_valid = 1'b0; m_seq = 8'd0;
        end else begin
            if (m_busy) begin
                if (cyc == m_due) begin
                    if (m_s2) begin
                        m_frame = make_frame(m_t, m_c);
                        m_valid = 1'b1;
                        m_seq++;
                    end
                    m_busy = 1'b0;
                end
            end else if (m_s2) begin
                m_t = time_in; m_c = cnt_flat; m_busy = 1'b1; m_due = cyc + LAT;
            end
            m_s2 = m_s1;
            m_s1 = ssel;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("frame_out", frame_out, m_frame);
        chk("frame_valid", FW'(frame_valid), FW'(m_valid));
        chk("frame_seq", FW'(frame_seq), FW'(m_seq));
    end

    task automatic rand_inputs();
        time_in = $urandom;
        for (int i = 0; i < NCNT; i++) cnt_flat = (cnt_flat << 32) | (32*NCNT)'($urandom);
    endtask

    logic [7:0]    pin_b [0:63];
    logic [7:0]    ref_b [0:63];
    logic [FW-1:0] hold_exp;
    logic [7:0]    hold_seq;
    logic [31:0]   exp_crc;

    initial begin
        // Pin the reference CRC with the standard check string.
        for (int i = 0; i < 64; i++) pin_b[i] = 8'h0;
        for (int i = 0; i < 9; i++) pin_b[i] = 8'(8'h31 + i);
        chk("crc_check_value", FW'(crc_ref(pin_b, 9)), FW'(32'hFC891918));

        // First snapshot on the first edge after reset release.
        rand_inputs();
        time_in = 32'hA5A5A5A5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rand_inputs();
        repeat (LAT-1) @(negedge clk);
        chk("valid_before_first", FW'(frame_valid), FW'(1'b0));
        @(negedge clk);
        chk("first_time_word", FW'(frame_out[FW-1 -: 32]), FW'(32'hA5A5A5A5));
        chk("first_valid", FW'(frame_valid), FW'(1'b1));
        chk("first_seq", FW'(frame_seq), FW'(8'd1));

        // Known-content frame for the CRC word.
        time_in  = 32'h31323334;
        cnt_flat = '0;
        cnt_flat[31:0]  = 32'h35363738;
        cnt_flat[63:32] = 32'h39000000;
        @(negedge clk);
        rand_inputs();
        repeat (LAT) @(negedge clk);
        for (int i = 0; i < 64; i++) ref_b[i] = 8'h0;
        for (int i = 0; i < 9; i++) ref_b[i] = 8'(8'h31 + i);
`ifdef FRAME_CRC_EN
        exp_crc = crc_ref(ref_b, 4*(NCNT+1));
`else
        exp_crc = 32'h0;
`endif
        chk("known_cnt0_word", FW'(frame_out[FW-33 -: 32]), FW'(32'h35363738));
        chk("known_crc_word", FW'(frame_out[31:0]), FW'(exp_crc));
        chk("known_seq", FW'(frame_seq), FW'(8'd2));

        // Reset in the middle of the CRC pass abandons the frame.
        repeat (21) begin @(negedge clk); rand_inputs(); end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", FW'(frame_valid), FW'(1'b0));
        chk("rst_seq", FW'(frame_seq), FW'(8'd0));
        chk("rst_frame", frame_out, '0);
        rst = 1'b0;
        repeat (LAT) begin @(negedge clk); rand_inputs(); end
        chk("rst_valid_before_publish", FW'(frame_valid), FW'(1'b0));
        @(negedge clk);
        chk("rst_valid_after_publish", FW'(frame_valid), FW'(1'b1));
        chk("rst_seq_after_publish", FW'(frame_seq), FW'(8'd1));

        // 256 more frames: the sequence wraps back to the same value.
        repeat (256*(LAT+1)) begin @(negedge clk); rand_inputs(); end
        chk("wrap_seq", FW'(frame_seq), FW'(8'd1));
        chk("wrap_valid", FW'(frame_valid), FW'(1'b1));

        // Transfer starts 10 clk after a snapshot and holds for 100 clk.
        repeat (10) begin @(negedge clk); rand_inputs(); end
        ssel = 1'b0;
        repeat (2) begin @(negedge clk); rand_inputs(); end
        hold_exp = m_frame;
        hold_seq = m_seq;
        repeat (98) begin
            @(negedge clk);
            rand_inputs();
            chk("hold_frame", frame_out, hold_exp);
            chk("hold_seq", FW'(frame_seq), FW'(hold_seq));
        end
        ssel = 1'b1;
        repeat (2+LAT) begin @(negedge clk); rand_inputs(); end
        chk("release_seq_before", FW'(frame_seq), FW'(hold_seq));
        @(negedge clk);
        chk("release_seq_after", FW'(frame_seq), FW'(hold_seq + 8'd1));

        // Random transfers, inputs and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rand_inputs();
            if ($urandom_range(0, 19) == 0) ssel = ~ssel;
            rst = ($urandom_range(0, 499) == 0);
        end
        rst  = 1'b0;
        ssel = 1'b1;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
